// File: rtl/axi_addr_decode_slice.sv
// Registered AXI address decoder slice.
// Maps an AW/AR address to a one-hot slave select or DECERR.
module axi_addr_decode_slice #(
  parameter int ADDR_WIDTH  = 32,
  parameter int ID_WIDTH    = 4,
  parameter int NUM_SLAVES  = 4,
  parameter int REGION_BITS = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_addr,
  input  logic [ID_WIDTH-1:0]   s_id,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [ID_WIDTH-1:0]   m_id,
  output logic [NUM_SLAVES-1:0] m_sel,
  output logic                  m_decerr,
  output logic                  m_valid,
  input  logic                  m_ready,
  input  logic                  err_clr,
  output logic [CNT_WIDTH-1:0]  err_count
);

  localparam int XW = ADDR_WIDTH + 2;

  localparam logic [XW-1:0] SPAN =
    XW'(NUM_SLAVES) << REGION_BITS;
  localparam logic [XW-1:0] END_A =
    XW'(BASE_ADDR) + SPAN;
  localparam logic [XW-1:0] LIMIT =
    XW'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] BASE_AL =
    (BASE_ADDR >> REGION_BITS) << REGION_BITS;

  if (END_A > LIMIT) begin : g_bad_span
    $error("slave regions overrun the address space");
  end
  if (BASE_AL != BASE_ADDR) begin : g_bad_align
    $error("BASE_ADDR not aligned to region size");
  end
  if (NUM_SLAVES < 1 || NUM_SLAVES > 16) begin : g_bad_num
    $error("NUM_SLAVES must be 1..16");
  end

  logic                  w_borrow;
  logic [ADDR_WIDTH-1:0] w_off;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_in_range;
  logic [NUM_SLAVES-1:0] w_sel;
  logic                  w_decerr;
  logic                  w_accept;

  logic                  r_valid;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ID_WIDTH-1:0]   r_id;
  logic [NUM_SLAVES-1:0] r_sel;
  logic                  r_decerr;
  logic [CNT_WIDTH-1:0]  r_cnt;

  // Borrow out of the offset subtraction means below BASE_ADDR.
  assign {w_borrow, w_off} =
    {1'b0, s_addr} - {1'b0, BASE_ADDR};
  assign w_idx      = w_off >> REGION_BITS;
  assign w_in_range = !w_borrow &&
    (w_idx < ADDR_WIDTH'(NUM_SLAVES));
  assign w_decerr   = !w_in_range;

  // One-hot select from the region index.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      w_sel[i] = w_in_range &&
        (w_idx == ADDR_WIDTH'(i));
    end
  end

  assign s_ready  = !rst && (!r_valid || m_ready);
  assign w_accept = s_valid && s_ready;

  // One-entry slice: load on accept, retire on m_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_addr   <= '0;
      r_id     <= '0;
      r_sel    <= '0;
      r_decerr <= 1'b0;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_addr   <= s_addr;
      r_id     <= s_id;
      r_sel    <= w_sel;
      r_decerr <= w_decerr;
    end else if (m_ready) begin
      r_valid  <= 1'b0;
    end
  end

  // Saturating DECERR counter; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      r_cnt <= '0;
    end else if (w_accept && w_decerr &&
                 (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign m_valid   = r_valid;
  assign m_addr    = r_addr;
  assign m_id      = r_id;
  assign m_sel     = r_sel;
  assign m_decerr  = r_decerr;
  assign err_count = r_cnt;

endmodule

// File: tb/tb_axi_addr_decode_slice.sv
// Testbench for axi_addr_decode_slice.
// Two instances: default map, and offset 8x64KiB map with 2-bit counter.
module tb_axi_addr_decode_slice;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [3:0]  id;
    logic [7:0]  sel;
    logic        dec;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  logic ev0 = 1'b0;
  logic ev1 = 1'b0;

  logic        rst0 = 1'b1, v0 = 1'b0, mr0 = 1'b0, clr0 = 1'b0;
  logic [31:0] a0 = '0;
  logic [3:0]  id0 = '0;
  logic        rdy0, mdec0, mv0;
  logic [31:0] ma0;
  logic [3:0]  mid0, msel0;
  logic [7:0]  cnt0;

  logic        rst1 = 1'b1, v1 = 1'b0, mr1 = 1'b0, clr1 = 1'b0;
  logic [31:0] a1 = '0;
  logic [3:0]  id1 = '0;
  logic        rdy1, mdec1, mv1;
  logic [31:0] ma1;
  logic [3:0]  mid1;
  logic [7:0]  msel1;
  logic [1:0]  cnt1;

  axi_addr_decode_slice u_dut0 (
    .clk(clk), .rst(rst0),
    .s_addr(a0), .s_id(id0),
    .s_valid(v0), .s_ready(rdy0),
    .m_addr(ma0), .m_id(mid0),
    .m_sel(msel0), .m_decerr(mdec0),
    .m_valid(mv0), .m_ready(mr0),
    .err_clr(clr0), .err_count(cnt0)
  );

  axi_addr_decode_slice #(
    .NUM_SLAVES(8), .REGION_BITS(16),
    .BASE_ADDR(32'h8000_0000), .CNT_WIDTH(2)
  ) u_dut1 (
    .clk(clk), .rst(rst1),
    .s_addr(a1), .s_id(id1),
    .s_valid(v1), .s_ready(rdy1),
    .m_addr(ma1), .m_id(mid1),
    .m_sel(msel1), .m_decerr(mdec1),
    .m_valid(mv1), .m_ready(mr1),
    .err_clr(clr1), .err_count(cnt1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc0(input logic v, input logic [31:0] a,
                      input logic [3:0] id, input logic mr,
                      input logic [3:0] esel, input logic edec);
    logic er;
    exp_t e;
    v0 = v; a0 = a; id0 = id; mr0 = mr;
    @(negedge clk);
    er = !rst0 && (!ev0 || mr);
    chk("s_ready0", 32'(rdy0), 32'(er));
    chk("m_valid0", 32'(mv0), 32'(ev0));
    if (rst0) begin
      q0.delete();
      ev0 = 1'b0;
    end else begin
      if (ev0 && mr) begin
        e = q0.pop_front();
        chk("m_addr0", ma0, e.a);
        chk("m_id0", 32'(mid0), 32'(e.id));
        chk("m_sel0", 32'(msel0), 32'(e.sel));
        chk("m_decerr0", 32'(mdec0), 32'(e.dec));
        ev0 = 1'b0;
      end
      if (v && er) begin
        e.a = a; e.id = id;
        e.sel = {4'b0, esel}; e.dec = edec;
        q0.push_back(e);
        ev0 = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc1(input logic v, input logic [31:0] a,
                      input logic [3:0] id, input logic mr,
                      input logic [7:0] esel, input logic edec);
    logic er;
    exp_t e;
    v1 = v; a1 = a; id1 = id; mr1 = mr;
    @(negedge clk);
    er = !rst1 && (!ev1 || mr);
    chk("s_ready1", 32'(rdy1), 32'(er));
    chk("m_valid1", 32'(mv1), 32'(ev1));
    if (rst1) begin
      q1.delete();
      ev1 = 1'b0;
    end else begin
      if (ev1 && mr) begin
        e = q1.pop_front();
        chk("m_addr1", ma1, e.a);
        chk("m_id1", 32'(mid1), 32'(e.id));
        chk("m_sel1", 32'(msel1), 32'(e.sel));
        chk("m_decerr1", 32'(mdec1), 32'(e.dec));
        ev1 = 1'b0;
      end
      if (v && er) begin
        e.a = a; e.id = id;
        e.sel = esel; e.dec = edec;
        q1.push_back(e);
        ev1 = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready0", 32'(rdy0), 0);
    chk("rst_valid0", 32'(mv0), 0);
    chk("rst_sel0", 32'(msel0), 0);
    chk("rst_decerr0", 32'(mdec0), 0);
    chk("rst_addr0", ma0, 0);
    chk("rst_id0", 32'(mid0), 0);
    chk("rst_cnt0", 32'(cnt0), 0);
    chk("rst_valid1", 32'(mv1), 0);
    chk("rst_cnt1", 32'(cnt1), 0);
    rst0 = 1'b0;
    rst1 = 1'b0;

    cyc0(1, 32'h0000_0FFF, 4'h1, 1, 4'b0001, 0);
    cyc0(1, 32'h0000_1000, 4'h2, 1, 4'b0010, 0);
    cyc0(1, 32'h0000_2ABC, 4'h3, 1, 4'b0100, 0);
    cyc0(1, 32'h0000_3FFF, 4'h4, 1, 4'b1000, 0);
    cyc0(0, 32'h0, 4'h0, 1, 4'b0000, 0);
    chk("cnt0_clean", 32'(cnt0), 0);

    cyc0(1, 32'h0000_4000, 4'h5, 1, 4'b0000, 1);
    chk("cnt0_step1", 32'(cnt0), 1);
    cyc0(1, 32'hFFFF_FFFC, 4'h6, 1, 4'b0000, 1);
    chk("cnt0_step2", 32'(cnt0), 2);
    cyc0(0, 32'h0, 4'h0, 1, 4'b0000, 0);

    cyc0(1, 32'h0000_1000, 4'h7, 0, 4'b0010, 0);
    for (int i = 0; i < 5; i++) begin
      cyc0(1, 32'h0000_2000, 4'h8, 0, 4'b0100, 0);
      chk("stall_addr0", ma0, 32'h0000_1000);
      chk("stall_sel0", 32'(msel0), 32'h2);
    end
    cyc0(1, 32'h0000_2000, 4'h8, 1, 4'b0100, 0);
    chk("nobubble_addr0", ma0, 32'h0000_2000);
    cyc0(0, 32'h0, 4'h0, 1, 4'b0000, 0);

    cyc0(1, 32'h0000_0000, 4'h9, 0, 4'b0001, 0);
    chk("pre_rst_cnt0", 32'(cnt0), 2);
    rst0 = 1'b1;
    cyc0(1, 32'h0000_3000, 4'hA, 0, 4'b1000, 0);
    rst0 = 1'b0;
    chk("post_rst_valid0", 32'(mv0), 0);
    chk("post_rst_sel0", 32'(msel0), 0);
    chk("post_rst_cnt0", 32'(cnt0), 0);
    cyc0(0, 32'h0, 4'h0, 1, 4'b0000, 0);

    cyc1(1, 32'h7FFF_FFFF, 4'h1, 1, 8'h00, 1);
    chk("cnt1_a", 32'(cnt1), 1);
    cyc1(1, 32'h8003_0010, 4'h2, 1, 8'h08, 0);
    chk("cnt1_b", 32'(cnt1), 1);
    cyc1(1, 32'h8008_0000, 4'h3, 1, 8'h00, 1);
    chk("cnt1_c", 32'(cnt1), 2);
    cyc1(1, 32'hFFFF_FFFF, 4'h4, 1, 8'h00, 1);
    chk("cnt1_sat3", 32'(cnt1), 3);
    cyc1(1, 32'h0000_0000, 4'h5, 1, 8'h00, 1);
    chk("cnt1_sat4", 32'(cnt1), 3);
    cyc1(1, 32'h8007_FFFF, 4'h6, 1, 8'h80, 0);
    cyc1(1, 32'h8010_0000, 4'h7, 1, 8'h00, 1);
    chk("cnt1_sat5", 32'(cnt1), 3);
    clr1 = 1'b1;
    cyc1(1, 32'h0000_1234, 4'h8, 1, 8'h00, 1);
    clr1 = 1'b0;
    chk("cnt1_clr", 32'(cnt1), 0);
    cyc1(0, 32'h0, 4'h0, 1, 8'h00, 0);

    chk("q0_drained", 32'(q0.size()), 0);
    chk("q1_drained", 32'(q1.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
